sector_rr_scheduler: RTL

//  Round-robin scheduler sharing one service resource among NUM_REQ sector requesters.

---
 rtl/sector_rr_scheduler.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sector_rr_scheduler.sv
// Round-robin grant of one shared resource across NUM_REQ sector requesters; grant is registered 1 cycle after req.
// A grant lasts 1..MAX_BURST cycles, followed by a mandatory one-cycle GAP; there is no backpressure on the outputs.
module sector_rr_scheduler #(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8,
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BC_W     = $clog2(MAX_BURST + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic               round_done,
  output logic [CNT_W-1:0]   grant_total
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [BC_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               busy_q, busy_d;
  logic               round_done_q, round_done_d;
  logic [CNT_W-1:0]   grant_total_q, grant_total_d;

  logic               found;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   scan_idx;
  int                 scan_j;
  logic               last_idx;
  logic               release_c;

  // First requester at or after ptr, wrapping past the last sector.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_j   = 0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_j = int'(ptr_q) + i;
      if (scan_j >= NUM_REQ) scan_j = scan_j - NUM_REQ;
      scan_idx = IDX_W'(scan_j);
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  assign last_idx  = (grant_idx_q == IDX_W'(NUM_REQ - 1));
  assign release_c = done[grant_idx_q] | ~req[grant_idx_q] |
                     (burst_cnt_q == BC_W'(MAX_BURST - 1));

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    burst_cnt_d   = burst_cnt_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_total_d = grant_total_q;
    round_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d        = ST_GRANT;
          grant_d        = '0;
          grant_d[win]   = 1'b1;
          grant_idx_d    = win;
          burst_cnt_d    = '0;
          if (grant_total_q != '1) grant_total_d = grant_total_q + 1'b1;
        end
      end
      ST_GRANT: begin
        burst_cnt_d = burst_cnt_q + 1'b1;
        if (release_c) begin
          state_d      = ST_GAP;
          grant_d      = '0;
          ptr_d        = last_idx ? '0 : grant_idx_q + 1'b1;
          round_done_d = last_idx;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_GRANT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      burst_cnt_q   <= '0;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      busy_q        <= 1'b0;
      round_done_q  <= 1'b0;
      grant_total_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      burst_cnt_q   <= burst_cnt_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      busy_q        <= busy_d;
      round_done_q  <= round_done_d;
      grant_total_q <= grant_total_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign busy        = busy_q;
  assign round_done  = round_done_q;
  assign grant_total = grant_total_q;

endmodule
